cache_write_buffer: RTL and testbench
=====================================

Name: cache_write_buffer

Overview:
- Write-through posting buffer that sits directly downstream of the cache controller's memory write path and upstream of main memory.
- Accepts write-through stores from the controller in one cycle and holds them in a small FIFO.
- Drains stores to main memory over a valid/ack handshake, so `cpu_ready` no longer waits on memory write latency.
- Coalesces repeated writes to a pending address and forwards pending data to the controller's read-miss path, so a refill never returns stale memory data.

Parameters:
- ADDR_WIDTH, 16, word address width, same as the cache system.
- DATA_WIDTH, 32, data word width.
- DEPTH, 4, number of buffer entries; power of two, ≥2.

Ports:
- clk  in  1  system clock, all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  controller presents a write.
- in_address  in  ADDR_WIDTH  write address.
- in_data  in  DATA_WIDTH  write data.
- in_ready  out  1  buffer can accept a write; equals (count < DEPTH).
- fwd_address  in  ADDR_WIDTH  read-miss address to check against pending writes.
- fwd_hit  out  1  a pending entry matches fwd_address (combinational).
- fwd_data  out  DATA_WIDTH  data of the youngest matching entry; 0 when no match.
- mem_write_enable  out  1  write request to main memory (registered).
- mem_address  out  ADDR_WIDTH  memory write address (registered).
- mem_write_data  out  DATA_WIDTH  memory write data (registered).
- mem_ack  in  1  memory has completed the current write.
- count  out  $clog2(DEPTH)+1  number of valid entries.
- empty  out  1  count == 0.

Behaviour:
- Reset (sync, rst=1 at an edge):
  - All entries are invalidated.
  - count=0, empty=1, in_ready=1.
  - mem_write_enable=0, mem_address=0, mem_write_data=0.
  - FSM=IDLE.
  - fwd_hit=0, fwd_data=0.
  - Reset mid-drain abandons the transfer; mem_write_enable is low after that edge, and pending writes are discarded.
- Accept: a write is taken at an edge where in_valid && in_ready. It becomes visible (count, fwd) after that edge. in_valid while in_ready=0 is ignored; there is no back-pressure memory.
- Coalesce: if an accepted in_address equals a valid entry that is not the head currently in DRAIN, that entry's data is overwritten in place and count is unchanged. A match only on the in-flight head allocates a new tail entry instead.
- Ordering: entries drain strictly FIFO; the tail pointer wraps modulo DEPTH.
- Drain FSM, states IDLE and DRAIN:
  - IDLE → DRAIN at an edge where count > 0 (as held before the edge). At that edge, mem_address/mem_write_data load the head entry and mem_write_enable goes to 1.
  - In DRAIN, mem_write_enable, mem_address and mem_write_data are held stable until mem_ack is sampled 1 at an edge.
  - On that ack edge: the head is popped, the head pointer advances, mem_write_enable goes to 0, and the FSM returns to IDLE. There is one idle cycle minimum between memory writes.
  - mem_ack is ignored in IDLE.
- Latency: a write accepted at edge N with the buffer empty and IDLE gives mem_write_enable=1 after edge N+1.
- Simultaneous events:
  - Accept and pop at the same edge: count unchanged.
  - Accept is allowed only if count < DEPTH before the edge, so there is no same-edge full bypass.
  - Coalesce and pop at the same edge target different entries by rule.
- Forwarding:
  - fwd_hit is combinational over all valid entries, including the in-flight head.
  - fwd_data selects the youngest match.
  - A write being accepted in the same cycle is not forwarded.
- count/empty are registered from pointer/valid state.

Test Plan:
- Basic drain: reset, write 0x0100/DEADBEEF, ack 3 cycles after mem_write_enable rises.
  - mem_write_enable=1 one edge after accept, with mem_address=0x0100, mem_write_data=DEADBEEF held until ack.
  - After ack: count=0, empty=1.
- Full/ordering: hold mem_ack=0, write 0x0500/11111111, 0x0504/22222222, 0x0508/33333333, 0x050C/44444444, then attempt 0x0510.
  - count=4, in_ready=0, 0x0510 is dropped.
  - Ack each write: memory sees the four writes in order, and in_ready=1 after the first ack.
- Coalesce: mem_ack=0, write 0x0300/A5A5A5A5, 0x0304/CAFEBABE, 0x0304/5A5A5A5A.
  - count=2.
  - Memory receives 0x0300/A5A5A5A5 then 0x0304/5A5A5A5A only.
- Forwarding: with 0x0100/DEADBEEF pending, drive fwd_address=0x0100 and then 0x0104.
  - 0x0100: fwd_hit=1, fwd_data=DEADBEEF.
  - 0x0104: fwd_hit=0, fwd_data=0.
- Head match: while 0x0020/AAAAAAAA is in DRAIN, write 0x0020/EEEEEEEE.
  - count=2, and fwd_address=0x0020 returns EEEEEEEE.
  - Memory sees AAAAAAAA then EEEEEEEE at 0x0020.
- Reset mid-drain: 3 entries pending, FSM in DRAIN, assert rst for one edge.
  - After the edge: mem_write_enable=0, count=0, empty=1, fwd_hit=0.
  - Subsequent mem_ack pulses have no effect.

Source files
------------

// File: rtl/cache_write_buffer.sv
// Write-through posting buffer between the cache controller and main memory.
// Stores are queued FIFO, coalesced by address, forwarded to read misses and drained over valid/ack.
module cache_write_buffer #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [ADDR_WIDTH-1:0]   in_address,
  input  logic [DATA_WIDTH-1:0]   in_data,
  output logic                    in_ready,
  input  logic [ADDR_WIDTH-1:0]   fwd_address,
  output logic                    fwd_hit,
  output logic [DATA_WIDTH-1:0]   fwd_data,
  output logic                    mem_write_enable,
  output logic [ADDR_WIDTH-1:0]   mem_address,
  output logic [DATA_WIDTH-1:0]   mem_write_data,
  input  logic                    mem_ack,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   entry_addr [DEPTH];
  logic [DATA_WIDTH-1:0]   entry_data [DEPTH];
  logic [DEPTH-1:0]        entry_valid;
  logic [PW-1:0]           head;
  logic [PW-1:0]           tail;

  logic                    accept;
  logic                    pop;
  logic                    coal_hit;
  logic [PW-1:0]           coal_idx;
  logic                    alloc;
  logic                    do_coal;
  logic [CW-1:0]           count_next;
  logic [PW-1:0]           fwd_idx;

  assign in_ready   = (count < CW'(DEPTH));
  assign accept     = in_valid && in_ready;
  assign pop        = (state == DRAIN) && mem_ack;
  assign alloc      = accept && !coal_hit;
  assign do_coal    = accept && coal_hit;
  assign count_next = count + CW'(alloc) - CW'(pop);

  // The head already on the memory bus must not change, so it is excluded from coalescing.
  // NOTE: every signal driven in always_comb gets a default first so no latch is inferred.
  always_comb begin
    coal_hit = 1'b0;
    coal_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i] && entry_addr[i] == in_address &&
          !(state == DRAIN && PW'(i) == head)) begin
        coal_hit = 1'b1;
        coal_idx = PW'(i);
      end
    end
  end

  // Walk from oldest to youngest so the last match wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      fwd_idx = head + PW'(k);
      if (entry_valid[fwd_idx] && entry_addr[fwd_idx] == fwd_address) begin
        fwd_hit  = 1'b1;
        fwd_data = entry_data[fwd_idx];
      end
    end
  end

  // NOTE: entry storage has no reset; the valid bits alone decide what is live.
  always_ff @(posedge clk) begin
    if (alloc) begin
      entry_addr[tail] <= in_address;
      entry_data[tail] <= in_data;
    end
    if (do_coal) begin
      entry_data[coal_idx] <= in_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      entry_valid      <= '0;
      head             <= '0;
      tail             <= '0;
      count            <= '0;
      empty            <= 1'b1;
      state            <= IDLE;
      mem_write_enable <= 1'b0;
      mem_address      <= '0;
      mem_write_data   <= '0;
    end else begin
      if (alloc) begin
        entry_valid[tail] <= 1'b1;
        tail              <= tail + 1'b1;
      end
      if (pop) begin
        entry_valid[head] <= 1'b0;
        head              <= head + 1'b1;
      end
      count <= count_next;
      empty <= (count_next == '0);

      case (state)
        IDLE: begin
          if (count != '0) begin
            state            <= DRAIN;
            mem_write_enable <= 1'b1;
            mem_address      <= entry_addr[head];
            // A same-edge coalesce into the head must reach memory, not the stale copy.
            mem_write_data   <= (do_coal && coal_idx == head) ? in_data : entry_data[head];
          end
        end
        DRAIN: begin
          if (mem_ack) begin
            state            <= IDLE;
            mem_write_enable <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_write_buffer.sv
// Directed bench for cache_write_buffer: scoreboard of expected memory writes,
// checked as each write appears on the memory port.
module tb_cache_write_buffer;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic [AW-1:0]   in_address = '0;
  logic [DW-1:0]   in_data = '0;
  logic            in_ready;
  logic [AW-1:0]   fwd_address = '0;
  logic            fwd_hit;
  logic [DW-1:0]   fwd_data;
  logic            mem_write_enable;
  logic [AW-1:0]   mem_address;
  logic [DW-1:0]   mem_write_data;
  logic            mem_ack = 1'b0;
  logic [2:0]      count;
  logic            empty;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t exp_q [$];

  cache_write_buffer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_address(in_address), .in_data(in_data), .in_ready(in_ready),
    .fwd_address(fwd_address), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
    .mem_write_enable(mem_write_enable), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_ack(mem_ack),
    .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic check(input logic [63:0] obs, input logic [63:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    in_valid   = 1'b1;
    in_address = a;
    in_data    = d;
    step();
    in_valid   = 1'b0;
  endtask

  task automatic fwd_check(input logic [AW-1:0] a, input logic hit, input logic [DW-1:0] d,
                           input string tag);
    fwd_address = a;
    #1;
    check(64'(fwd_hit), 64'(hit), {tag, "_hit"});
    check(64'(fwd_data), 64'(d), {tag, "_data"});
  endtask

  // Wait for the next memory write, compare against the scoreboard, hold for delay cycles, then ack.
  task automatic ack_next(input int delay);
    wr_t e;
    for (int i = 0; i < 20 && mem_write_enable !== 1'b1; i++) step();
    check(64'(mem_write_enable), 64'd1, "drain_start");
    if (exp_q.size() == 0) begin
      check(64'd0, 64'd1, "scoreboard_underflow");
      return;
    end
    e = exp_q.pop_front();
    check(64'(mem_address), 64'(e.addr), "mem_address");
    check(64'(mem_write_data), 64'(e.data), "mem_write_data");
    for (int i = 0; i < delay; i++) begin
      step();
      check(64'(mem_write_enable), 64'd1, "hold_enable");
      check(64'(mem_address), 64'(e.addr), "hold_address");
      check(64'(mem_write_data), 64'(e.data), "hold_data");
    end
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    check(64'(mem_write_enable), 64'd0, "enable_drops_after_ack");
  endtask

  initial begin
    // Reset state
    step();
    step();
    rst = 1'b0;
    check(64'(count), 64'd0, "rst_count");
    check(64'(empty), 64'd1, "rst_empty");
    check(64'(in_ready), 64'd1, "rst_in_ready");
    check(64'(mem_write_enable), 64'd0, "rst_mem_we");
    check(64'(mem_address), 64'd0, "rst_mem_address");
    check(64'(mem_write_data), 64'd0, "rst_mem_data");
    fwd_check(16'h0100, 1'b0, 32'h0, "rst_fwd");

    // Basic drain with forwarding while pending
    exp_q.push_back('{addr: 16'h0100, data: 32'hDEADBEEF});
    write(16'h0100, 32'hDEADBEEF);
    check(64'(count), 64'd1, "basic_count");
    check(64'(mem_write_enable), 64'd0, "basic_not_yet");
    fwd_check(16'h0100, 1'b1, 32'hDEADBEEF, "fwd_match");
    fwd_check(16'h0104, 1'b0, 32'h0, "fwd_miss");
    step();
    check(64'(mem_write_enable), 64'd1, "basic_latency");
    ack_next(3);
    check(64'(count), 64'd0, "basic_count_after");
    check(64'(empty), 64'd1, "basic_empty_after");

    // Full and ordering
    exp_q.push_back('{addr: 16'h0500, data: 32'h11111111});
    exp_q.push_back('{addr: 16'h0504, data: 32'h22222222});
    exp_q.push_back('{addr: 16'h0508, data: 32'h33333333});
    exp_q.push_back('{addr: 16'h050C, data: 32'h44444444});
    write(16'h0500, 32'h11111111);
    write(16'h0504, 32'h22222222);
    write(16'h0508, 32'h33333333);
    write(16'h050C, 32'h44444444);
    check(64'(count), 64'd4, "full_count");
    check(64'(in_ready), 64'd0, "full_in_ready");
    write(16'h0510, 32'h55555555);
    check(64'(count), 64'd4, "full_drop_count");
    fwd_check(16'h0510, 1'b0, 32'h0, "full_drop_fwd");
    ack_next(0);
    check(64'(in_ready), 64'd1, "full_ready_after_ack");
    check(64'(count), 64'd3, "full_count_after_ack");
    ack_next(1);
    ack_next(0);
    ack_next(2);
    check(64'(empty), 64'd1, "full_empty_after");

    // Coalesce
    exp_q.push_back('{addr: 16'h0300, data: 32'hA5A5A5A5});
    exp_q.push_back('{addr: 16'h0304, data: 32'h5A5A5A5A});
    write(16'h0300, 32'hA5A5A5A5);
    write(16'h0304, 32'hCAFEBABE);
    write(16'h0304, 32'h5A5A5A5A);
    check(64'(count), 64'd2, "coal_count");
    fwd_check(16'h0304, 1'b1, 32'h5A5A5A5A, "coal_fwd");
    ack_next(0);
    ack_next(1);
    check(64'(count), 64'd0, "coal_count_after");

    // Head match while draining
    exp_q.push_back('{addr: 16'h0020, data: 32'hAAAAAAAA});
    exp_q.push_back('{addr: 16'h0020, data: 32'hEEEEEEEE});
    write(16'h0020, 32'hAAAAAAAA);
    step();
    check(64'(mem_write_enable), 64'd1, "head_in_drain");
    write(16'h0020, 32'hEEEEEEEE);
    check(64'(count), 64'd2, "head_count");
    fwd_check(16'h0020, 1'b1, 32'hEEEEEEEE, "head_fwd_youngest");
    check(64'(mem_write_data), 64'hAAAAAAAA, "head_bus_stable");
    ack_next(0);
    ack_next(0);
    check(64'(empty), 64'd1, "head_empty_after");

    // Reset mid-drain
    write(16'h0600, 32'h66666666);
    write(16'h0604, 32'h77777777);
    write(16'h0608, 32'h88888888);
    check(64'(mem_write_enable), 64'd1, "mid_drain_active");
    check(64'(count), 64'd3, "mid_drain_count");
    rst = 1'b1;
    step();
    rst = 1'b0;
    check(64'(mem_write_enable), 64'd0, "mid_rst_mem_we");
    check(64'(count), 64'd0, "mid_rst_count");
    check(64'(empty), 64'd1, "mid_rst_empty");
    fwd_check(16'h0600, 1'b0, 32'h0, "mid_rst_fwd");
    for (int i = 0; i < 2; i++) begin
      mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
      step();
    end
    check(64'(mem_write_enable), 64'd0, "post_rst_ack_we");
    check(64'(count), 64'd0, "post_rst_ack_count");
    check(64'(in_ready), 64'd1, "post_rst_ack_ready");
    check(64'(exp_q.size()), 64'd0, "scoreboard_drained");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
